mips_mem_arbiter: RTL and testbench

Single-port memory arbiter for the in-order MIPS32 pipeline. It shares one word-addressed instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port. Data accesses have priority, and a starvation counter guarantees fetch progress. A fetch whose response is in flight is discarded when the pipeline takes a branch.

---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/mips_mem_arbiter_if.sv | 52 +++++
 rtl/mips_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mips_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the MIPS32 instruction/data memory path.
package mips_mem_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bundle of the fetch port, data port and single memory port around the arbiter.
interface mips_mem_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              flush;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        output if_req, if_addr, flush,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

    modport slave (
        input  if_req, if_addr, flush,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: data port has priority, a starvation counter
// forces fetch progress, and a flush discards the in-flight fetch response.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk1,
    input  logic               reset,
    mips_mem_arbiter_if.slave  bus
);

    localparam int               LAT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int               SW         = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT - 1);
    localparam logic [SW-1:0]    STARVE_TOP = SW'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              kill_q, kill_d;
    logic              st_q, st_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic gnt_if, gnt_dm, fetch_starved;

    // Grants are combinational from the requests while IDLE; reset masks them.
    always_comb begin
        fetch_starved = bus.if_req && (starve_q == STARVE_TOP);
        gnt_dm        = !reset && (state_q == IDLE) && bus.dm_req && !fetch_starved;
        gnt_if        = !reset && (state_q == IDLE) && !gnt_dm && bus.if_req;
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.dm_gnt    = gnt_dm;
    assign bus.mem_en    = gnt_if || gnt_dm;
    assign bus.mem_we    = gnt_dm && bus.dm_we;
    assign bus.mem_addr  = gnt_dm ? bus.dm_addr : (gnt_if ? bus.if_addr : '0);
    assign bus.mem_wdata = gnt_dm ? bus.dm_wdata : '0;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        st_d        = st_q;
        lat_d       = lat_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_dm || gnt_if) begin
                    state_d = WAIT;
                    owner_d = gnt_dm ? OWN_DM : OWN_IF;
                    kill_d  = gnt_if && bus.flush;
                    st_d    = gnt_dm && bus.dm_we;
                    lat_d   = LAT_INIT;
                end
            end
            WAIT: begin
                // A flush landing in the capture cycle still suppresses delivery.
                if (owner_q == OWN_IF && bus.flush) kill_d = 1'b1;
                if (lat_q == '0) begin
                    state_d = IDLE;
                    if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = st_q ? '0 : bus.mem_rdata;
                    end else if (!kill_d) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (!bus.if_req || gnt_if)
            starve_d = '0;
        else if (gnt_dm && starve_q != STARVE_TOP)
            starve_d = starve_q + SW'(1);
        else
            starve_d = starve_q;
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            kill_q      <= 1'b0;
            st_q        <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            st_q        <= st_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomised bench for mips_mem_arbiter against a cycle-count transaction model.
module tb_mips_mem_arbiter;
    import mips_mem_pkg::*;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic clk1 = 1'b0;
    logic reset;
    always #5 clk1 = ~clk1;

    mips_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mips_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk1 (clk1),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [DATA_W-1:0] init_word(input int a);
        if (a == 5) return 32'h0000_002A;
        return (a * 32'h9E37_79B9) ^ 32'h0123_4567;
    endfunction

    // Memory with MEM_LAT-stage read delay.
    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] pipe [MEM_LAT];
    bit mem_loaded = 1'b0;
    always @(posedge clk1) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        pipe[0] <= mem[bus.mem_addr];
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[MEM_LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: memory image, busy-until cycle, one outstanding response.
    logic [DATA_W-1:0] ref_mem [1024];
    int                free_cyc;
    int                starve;
    bit                pv, p_is_if, p_kill;
    int                p_due;
    logic [DATA_W-1:0] p_data;
    logic [DATA_W-1:0] exp_if_rdata, exp_dm_rdata;

    // Requester state.
    bit                if_pend, dm_pend, dm_w, flush_v, rst_v;
    bit                keep_if, keep_dm, keep_load;
    logic [ADDR_W-1:0] if_a, dm_a;
    logic [DATA_W-1:0] dm_wd;

    task automatic new_dm(input bit load_only);
        dm_pend = 1'b1;
        dm_w    = load_only ? 1'b0 : 1'($urandom_range(0, 1));
        dm_a    = ADDR_W'($urandom_range(0, 31));
        dm_wd   = $urandom;
    endtask

    task automatic drive();
        reset        = rst_v;
        bus.if_req   = if_pend;
        bus.if_addr  = if_a;
        bus.flush    = flush_v;
        bus.dm_req   = dm_pend;
        bus.dm_we    = dm_w;
        bus.dm_addr  = dm_a;
        bus.dm_wdata = dm_wd;
    endtask

    task automatic run_cycle();
        bit e_ifv, e_dmv, idle, g_if, g_dm;
        logic [ADDR_W-1:0] e_addr;
        drive();
        #2;
        e_ifv = 1'b0;
        e_dmv = 1'b0;
        if (pv && p_due == cyc) begin
            if (!p_kill) begin
                if (p_is_if) begin e_ifv = 1'b1; exp_if_rdata = p_data; end
                else         begin e_dmv = 1'b1; exp_dm_rdata = p_data; end
            end
            pv = 1'b0;
        end
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_ifv));
        chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(e_dmv));
        chk("if_rdata",  bus.if_rdata, exp_if_rdata);
        chk("dm_rdata",  bus.dm_rdata, exp_dm_rdata);
        chk("busy",      32'(bus.busy), 32'(cyc < free_cyc));

        idle = (cyc >= free_cyc);
        g_dm = !rst_v && idle && dm_pend && !(if_pend && starve == STARVE_MAX);
        g_if = !rst_v && idle && !g_dm && if_pend;
        e_addr = g_dm ? dm_a : (g_if ? if_a : '0);
        chk("if_gnt",    32'(bus.if_gnt), 32'(g_if));
        chk("dm_gnt",    32'(bus.dm_gnt), 32'(g_dm));
        chk("mem_en",    32'(bus.mem_en), 32'(g_if || g_dm));
        chk("mem_we",    32'(bus.mem_we), 32'(g_dm && dm_w));
        chk("mem_addr",  32'(bus.mem_addr), 32'(e_addr));
        chk("mem_wdata", bus.mem_wdata, g_dm ? dm_wd : 32'h0);

        if (g_if || g_dm) begin
            pv       = 1'b1;
            p_is_if  = g_if;
            p_kill   = 1'b0;
            p_due    = cyc + MEM_LAT + 1;
            free_cyc = p_due;
            if (g_if) p_data = ref_mem[if_a];
            else if (dm_w) begin ref_mem[dm_a] = dm_wd; p_data = '0; end
            else p_data = ref_mem[dm_a];
        end
        if (flush_v && pv && p_is_if && cyc < p_due) p_kill = 1'b1;

        if (!if_pend || g_if) starve = 0;
        else if (g_dm && starve < STARVE_MAX) starve++;

        if (rst_v) begin
            pv = 1'b0;
            free_cyc = cyc + 1;
            starve = 0;
            exp_if_rdata = '0;
            exp_dm_rdata = '0;
        end

        if (g_if) begin
            if (keep_if) if_a = ADDR_W'($urandom_range(0, 31));
            else if_pend = 1'b0;
        end
        if (g_dm) begin
            if (keep_dm) new_dm(keep_load);
            else dm_pend = 1'b0;
        end
        @(posedge clk1);
        #1;
        cyc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        free_cyc = 0; starve = 0; pv = 1'b0; p_is_if = 1'b0; p_kill = 1'b0;
        p_due = 0; p_data = '0; exp_if_rdata = '0; exp_dm_rdata = '0;
        keep_if = 1'b0; keep_dm = 1'b0; keep_load = 1'b0;
        if_pend = 1'b0; dm_pend = 1'b0; dm_w = 1'b0; flush_v = 1'b0;
        if_a = '0; dm_a = '0; dm_wd = '0;
        rst_v = 1'b1;
        drive();
        repeat (3) @(posedge clk1);
        #1;

        // Reset cycle with both requests up: no grant, all outputs at reset value.
        if_pend = 1'b1; dm_pend = 1'b1; if_a = 10'd3; dm_a = 10'd4;
        run_cycle();
        rst_v = 1'b0; if_pend = 1'b0; dm_pend = 1'b0;
        run_n(2);

        // Fetch of address 5 returns 0x2A three cycles after the grant.
        if_pend = 1'b1; if_a = 10'd5;
        run_n(5);

        // Store 0xDEAD to 9, then load it back.
        dm_pend = 1'b1; dm_w = 1'b1; dm_a = 10'd9; dm_wd = 32'h0000_DEAD;
        run_n(4);
        dm_pend = 1'b1; dm_w = 1'b0; dm_a = 10'd9; dm_wd = '0;
        run_n(5);

        // Both ports hammering: D,D,D,I pattern.
        keep_if = 1'b1; keep_dm = 1'b1;
        if_pend = 1'b1; if_a = 10'd7;
        new_dm(1'b0);
        run_n(40);
        keep_if = 1'b0; keep_dm = 1'b0;
        run_n(12);

        // Fetch granted, flushed one cycle later.
        if_pend = 1'b1; if_a = 10'd12;
        run_cycle();
        flush_v = 1'b1;
        run_cycle();
        flush_v = 1'b0;
        if_pend = 1'b1; if_a = 10'd13;
        run_n(6);

        // Flush in the capture cycle, then in the rvalid cycle.
        if_pend = 1'b1; if_a = 10'd14;
        run_n(2);
        flush_v = 1'b1; run_cycle(); flush_v = 1'b0;
        if_pend = 1'b1; if_a = 10'd15;
        run_n(3);
        flush_v = 1'b1; run_cycle(); flush_v = 1'b0;
        run_n(2);

        // Reset one cycle into a load.
        dm_pend = 1'b1; dm_w = 1'b0; dm_a = 10'd9;
        run_cycle();
        rst_v = 1'b1; run_cycle(); rst_v = 1'b0;
        run_n(5);

        // Back-to-back loads.
        keep_dm = 1'b1; keep_load = 1'b1;
        new_dm(1'b1);
        run_n(20);
        keep_dm = 1'b0; keep_load = 1'b0;
        run_n(6);

        // Random traffic with flushes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                if_a = ADDR_W'($urandom_range(0, 31));
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) new_dm(1'b0);
            flush_v = ($urandom_range(0, 5) == 0);
            rst_v   = ($urandom_range(0, 149) == 0);
            run_cycle();
        end
        flush_v = 1'b0; rst_v = 1'b0; if_pend = 1'b0; dm_pend = 1'b0;
        run_n(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
